// File: rtl/fir_mac_pkg.sv
// Shared constants and FSM state type for the sequential FIR MAC.
// Widths: 3-bit signed taps, 16-bit signed coefficients, 19-bit products, 23-bit accumulator.
// No ports; imported by fir_mac_seq and fir_coef_bank.
package fir_mac_pkg;

  localparam int TAP_NUM = 10;
  localparam int TAP_W   = 3;
  localparam int COEF_W  = 16;
  localparam int PROD_W  = 19;
  localparam int ACC_W   = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient storage: shadow written any time, active refreshed by copy strobe.
// Latency: a write lands in the shadow on the next edge; copy_i moves shadow->active on the next edge.
// Ports: clk_i/rst_ni, write port (wr_en_i/wr_addr_i/wr_data_i), copy_i, coef_o (active set). No backpressure.
module fir_coef_bank
  import fir_mac_pkg::*;
#(
  parameter int TAP_NUM = 10,
  parameter int COEF_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [3:0]               wr_addr_i,
  input  logic signed [COEF_W-1:0] wr_data_i,
  input  logic                     copy_i,
  output logic signed [COEF_W-1:0] coef_o [TAP_NUM]
);

  logic signed [COEF_W-1:0] shadow_q [TAP_NUM];
  logic signed [COEF_W-1:0] active_q [TAP_NUM];

  // Addresses at or above TAP_NUM match no entry and are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < TAP_NUM; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TAP_NUM; i++) begin
        if (wr_en_i && (wr_addr_i == 4'(i))) begin
          shadow_q[i] <= wr_data_i;
        end
        // A write in the same cycle as the copy bypasses the shadow so the
        // pass being loaded already sees the new value.
        if (copy_i) begin
          if (wr_en_i && (wr_addr_i == 4'(i))) begin
            active_q[i] <= wr_data_i;
          end else begin
            active_q[i] <= shadow_q[i];
          end
        end
      end
    end
  end

  assign coef_o = active_q;

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential 10-tap FIR MAC: one multiply-accumulate per clock over a snapshot of the delay chain.
// Latency: oMacValid pulses 12 cycles after the edge that samples iEnSample600k; busy for those 12 cycles.
// Backpressure: none; a strobe while busy is dropped and latches the sticky oOverrun flag.
// Ports: iClk12M/iRsn, iEnSample600k strobe, iDelay taps, coefficient write port, oMac/oMacValid/oBusy/oOverrun.
module fir_mac_seq
  import fir_mac_pkg::*;
#(
  parameter int TAP_NUM = 10,
  parameter int COEF_W  = 16
) (
  input  logic                            iClk12M,
  input  logic                            iRsn,
  input  logic                            iEnSample600k,
  input  logic [TAP_NUM*TAP_W-1:0]        iDelay,
  input  logic                            iCoefWrEn,
  input  logic [3:0]                      iCoefAddr,
  input  logic signed [COEF_W-1:0]        iCoefData,
  output logic signed [ACC_W-1:0]         oMac,
  output logic                            oMacValid,
  output logic                            oBusy,
  output logic                            oOverrun
);

  localparam int IDX_W = $clog2(TAP_NUM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAP_NUM - 1);

  fir_state_e               state_q;
  logic signed [TAP_W-1:0]  snap_q [TAP_NUM];
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic [IDX_W-1:0]         idx_q;
  logic signed [ACC_W-1:0]  mac_q;
  logic                     mac_vld_q;
  logic                     busy_q;
  logic                     overrun_q;

  logic signed [COEF_W-1:0] coef_act [TAP_NUM];
  logic signed [TAP_W-1:0]  tap_sel;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [PROD_W-1:0] prod;
  logic                     copy_en;

  // Active coefficients are refreshed exactly when the tap snapshot is taken.
  assign copy_en = (state_q == ST_LOAD);

  fir_coef_bank #(
    .TAP_NUM (TAP_NUM),
    .COEF_W  (COEF_W)
  ) u_coef_bank (
    .clk_i     (iClk12M),
    .rst_ni    (iRsn),
    .wr_en_i   (iCoefWrEn),
    .wr_addr_i (iCoefAddr),
    .wr_data_i (iCoefData),
    .copy_i    (copy_en),
    .coef_o    (coef_act)
  );

  // Both operands are sign-extended to the product width before multiplying,
  // so the 3x16 product is exact; the accumulator is wide enough for ten of them.
  always_comb begin
    tap_sel  = snap_q[idx_q];
    coef_sel = coef_act[idx_q];
    prod     = PROD_W'(tap_sel) * PROD_W'(coef_sel);
    acc_d    = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q   <= ST_IDLE;
      for (int k = 0; k < TAP_NUM; k++) begin
        snap_q[k] <= '0;
      end
      acc_q     <= '0;
      idx_q     <= '0;
      mac_q     <= '0;
      mac_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      mac_vld_q <= 1'b0;

      // A strobe seen mid-pass is dropped; only the sticky flag records it.
      if (iEnSample600k && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (iEnSample600k) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end

        ST_LOAD: begin
          for (int k = 0; k < TAP_NUM; k++) begin
            snap_q[k] <= iDelay[k*TAP_W +: TAP_W];
          end
          acc_q   <= '0;
          idx_q   <= '0;
          state_q <= ST_ACC;
        end

        ST_ACC: begin
          acc_q <= acc_d;
          if (idx_q == IDX_LAST) begin
            idx_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        ST_DONE: begin
          mac_q     <= acc_q;
          mac_vld_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oMac      = mac_q;
  assign oMacValid = mac_vld_q;
  assign oBusy     = busy_q;
  assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: directed corner passes plus randomized passes
// against a dot-product reference model of the coefficient bank and tap vector.
module tb_fir_mac_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               strobe;
  logic [29:0]        dly;
  logic               wr_en;
  logic [3:0]         addr;
  logic signed [15:0] wdata;
  logic signed [22:0] mac;
  logic               vld;
  logic               busy;
  logic               ovr;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int coef_m [10];

  always #5 clk = ~clk;

  fir_mac_seq #(
    .TAP_NUM (10),
    .COEF_W  (16)
  ) dut (
    .iClk12M       (clk),
    .iRsn          (rst_n),
    .iEnSample600k (strobe),
    .iDelay        (dly),
    .iCoefWrEn     (wr_en),
    .iCoefAddr     (addr),
    .iCoefData     (wdata),
    .oMac          (mac),
    .oMacValid     (vld),
    .oBusy         (busy),
    .oOverrun      (ovr)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: plain signed dot product of the 3-bit taps with the coefficients.
  function automatic longint dot(input logic [29:0] d);
    longint s;
    logic signed [2:0] t;
    s = 0;
    for (int k = 0; k < 10; k++) begin
      t = d[3*k +: 3];
      s += longint'(t) * longint'(coef_m[k]);
    end
    return s;
  endfunction

  task automatic wr_coef(input logic [3:0] a, input int v);
    wr_en = 1'b1;
    addr  = a;
    wdata = 16'(v);
    if (a < 4'd10) coef_m[a] = int'(wdata);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic launch(input logic [29:0] d);
    dly    = d;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    cyc    = 0;
  endtask

  task automatic wait_result(input string tag, input longint exp);
    int lat;
    lat = -1;
    while (cyc < 40) begin
      tick();
      if (vld) begin
        lat = cyc;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 12);
    chk({tag, "_mac"}, mac, exp);
    chk({tag, "_busy"}, busy, 0);
    tick();
    chk({tag, "_pulse"}, vld, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [29:0] d;
    longint e;
    int pulses;
    longint seen;

    rst_n = 1'b0; strobe = 1'b0; dly = '0; wr_en = 1'b0; addr = '0; wdata = '0;
    for (int k = 0; k < 10; k++) coef_m[k] = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_mac", mac, 0);
    chk("rst_vld", vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);

    // All ones: ten products of 1*1.
    for (int k = 0; k < 10; k++) wr_coef(4'(k), 1);
    d = '0;
    for (int k = 0; k < 10; k++) d[3*k +: 3] = 3'b001;
    launch(d);
    chk("ones_busy", busy, 1);
    wait_result("ones", 10);

    // Coefs 1..10: single tap active at each end.
    for (int k = 0; k < 10; k++) wr_coef(4'(k), k + 1);
    launch(30'b100);
    wait_result("tap0_neg", -4);
    d = '0;
    d[29:27] = 3'b011;
    launch(d);
    wait_result("tap9", 30);

    // Worst-case magnitude must not wrap.
    for (int k = 0; k < 10; k++) wr_coef(4'(k), -32768);
    d = {10{3'b100}};
    launch(d);
    wait_result("max", 1310720);

    // Write coinciding with LOAD is seen by that same pass.
    d = '0;
    for (int k = 0; k < 10; k++) d[3*k +: 3] = 3'b001;
    launch(d);
    wr_coef(4'd0, 5);
    wait_result("wr_load", -294907);

    // Write during ACC affects only the next pass.
    launch(d);
    e = dot(d);
    tick(); tick();
    wr_coef(4'd3, 7);
    wait_result("wr_acc_cur", e);
    launch(d);
    wait_result("wr_acc_next", dot(d));
    wr_coef(4'd12, 1234);
    launch(d);
    wait_result("wr_bad_addr", dot(d));

    // Randomized coefficient sets and tap vectors.
    for (int p = 0; p < 12; p++) begin
      for (int k = 0; k < 10; k++) wr_coef(4'(k), int'($urandom_range(0, 65535)) - 32768);
      d = 30'($urandom);
      launch(d);
      wait_result($sformatf("rnd%0d", p), dot(d));
    end
    chk("no_ovr", ovr, 0);

    // Second strobe five cycles into a pass is dropped and flagged.
    d = 30'($urandom);
    e = dot(d);
    launch(d);
    repeat (4) tick();
    dly    = 30'($urandom);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    pulses = 0;
    seen   = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (vld) begin
        pulses++;
        seen = mac;
      end
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_mac", seen, e);
    chk("ovr_flag", ovr, 1);
    launch(d);
    wait_result("ovr_after", e);
    chk("ovr_sticky", ovr, 1);

    // Reset six cycles into a pass aborts it and clears everything.
    launch(d);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_mac", mac, 0);
    chk("arst_busy", busy, 0);
    chk("arst_vld", vld, 0);
    chk("arst_ovr", ovr, 0);
    for (int k = 0; k < 10; k++) coef_m[k] = 0;
    tick(); tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vld) pulses++;
    end
    chk("arst_nopulse", pulses, 0);
    d = {10{3'b011}};
    launch(d);
    wait_result("post_rst_zero", 0);
    for (int k = 0; k < 10; k++) wr_coef(4'(k), int'($urandom_range(0, 65535)) - 32768);
    d = 30'($urandom);
    launch(d);
    wait_result("post_rst", dot(d));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
